// File: rtl/alu_pkg.sv
// Shared opcode and FSM state definitions for the registered ALU.
package alu_pkg;

  localparam logic [2:0] OP_NEG   = 3'b000;
  localparam logic [2:0] OP_INC   = 3'b001;
  localparam logic [2:0] OP_ADC   = 3'b010;
  localparam logic [2:0] OP_ADDSH = 3'b011;
  localparam logic [2:0] OP_AND   = 3'b100;
  localparam logic [2:0] OP_OR    = 3'b101;
  localparam logic [2:0] OP_MIX   = 3'b110;
  localparam logic [2:0] OP_MUL   = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier, one partial product per clock.
module alu_mul_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] mcand_in,
  input  logic [WIDTH-1:0] mplr_in,
  output logic             done,
  output logic [WIDTH-1:0] prod_lo,
  output logic [WIDTH-1:0] prod_hi
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplr;
  logic [WIDTH:0]   acc;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   sum;

  // Add the multiplicand when the multiplier LSB is set; the post-shift
  // values are exported so the final product is available at the last edge.
  always_comb begin
    sum     = acc + (mplr[0] ? {1'b0, mcand} : '0);
    prod_hi = sum[WIDTH:1];
    prod_lo = {sum[0], mplr[WIDTH-1:1]};
    done    = (cnt == CW'(1));
  end

  // Operand, accumulator and step counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand <= '0;
      mplr  <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else if (start) begin
      mcand <= mcand_in;
      mplr  <= mplr_in;
      acc   <= '0;
      cnt   <= CW'(WIDTH);
    end else if (cnt != '0) begin
      acc   <= {1'b0, prod_hi};
      mplr  <= prod_lo;
      cnt   <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU: single-cycle add/logic ops plus a multi-cycle multiply.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       opc,
  input  logic [WIDTH-1:0] ina,
  input  logic [WIDTH-1:0] inb,
  input  logic             inc,
  output logic             out_valid,
  output logic [WIDTH-1:0] w,
  output logic             zer,
  output logic             neg,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned H = WIDTH / 2;

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_lo;
  logic [WIDTH-1:0] mul_hi;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_c;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res;
  logic             res_cout;
  logic             res_ovf;

  assign in_ready  = (state == ST_IDLE);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (opc == OP_MUL);

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (mul_start),
    .mcand_in (ina),
    .mplr_in  (inb),
    .done     (mul_done),
    .prod_lo  (mul_lo),
    .prod_hi  (mul_hi)
  );

  // All 0xx opcodes share one adder; negate is ~ina + 0 with carry-in 1.
  always_comb begin
    add_a = ina;
    add_b = '0;
    add_c = 1'b0;
    case (opc)
      OP_NEG:   begin add_a = ~ina; add_c = 1'b1; end
      OP_INC:   add_c = 1'b1;
      OP_ADC:   begin add_b = inb; add_c = inc; end
      OP_ADDSH: add_b = WIDTH'($signed(inb) >>> 1);
      default:  ;
    endcase
    sum = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_c};
  end

  // Result and carry/overflow selection for single-cycle operations.
  always_comb begin
    res      = '0;
    res_cout = 1'b0;
    res_ovf  = 1'b0;
    case (opc)
      OP_NEG, OP_INC, OP_ADC, OP_ADDSH: begin
        res      = sum[WIDTH-1:0];
        res_cout = sum[WIDTH];
        res_ovf  = (add_a[WIDTH-1] == add_b[WIDTH-1]) &&
                   (sum[WIDTH-1] != add_a[WIDTH-1]);
      end
      OP_AND:  res = ina & inb;
      OP_OR:   res = ina | inb;
      OP_MIX:  res = {ina[H-1:0], inb[H-1:0]};
      default: ;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (mul_start) state_nxt = ST_MUL;
      ST_MUL:  if (mul_done)  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Result/flag registers; they hold between results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      w         <= '0;
      zer       <= 1'b0;
      neg       <= 1'b0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (accept && (opc != OP_MUL)) begin
        out_valid <= 1'b1;
        w         <= res;
        zer       <= (res == '0);
        neg       <= res[WIDTH-1];
        cout      <= res_cout;
        ovf       <= res_ovf;
      end else if ((state == ST_MUL) && mul_done) begin
        out_valid <= 1'b1;
        w         <= mul_lo;
        zer       <= (mul_lo == '0);
        neg       <= mul_lo[WIDTH-1];
        cout      <= |mul_hi;
        ovf       <= 1'b0;
      end
    end
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the team's 16-bit combinational ALU. Executes the same seven single-cycle operations at any even width, adds a multi-cycle unsigned shift-add multiply, and registers all results and flags behind a valid/ready handshake. Sits between the operand register file and the writeback stage of the datapath.

## Interface

- WIDTH, 16: operand/result width; must be even and ≥ 4.
- clk  in  1  rising-edge clock.
- rst_n  in  1  one clock; reset is asynchronous and active-low.
- in_valid  in  1  operation request.
- in_ready  out  1  high when a request can be accepted.
- opc  in  3  opcode.
- ina, inb  in  WIDTH  signed operands.
- inc  in  1  carry-in, used only by opc 010.
- out_valid  out  1  one-cycle pulse: w and flags updated this cycle.
- w  out  WIDTH  result.
- zer, neg, cout, ovf  out  1 each  flags for w.

## Operation

- Accept on a clk edge with in_valid && in_ready. Operands, opc and inc are sampled only at acceptance.
- Opcodes (all arithmetic is modulo 2^WIDTH):
  - 000: ~ina + 1.
  - 001: ina + 1.
  - 010: ina + inb + inc.
  - 011: ina + (inb >>> 1), arithmetic shift.
  - 100: ina & inb.
  - 101: ina | inb.
  - 110: {ina[WIDTH/2-1:0], inb[WIDTH/2-1:0]}.
  - 111: unsigned ina*inb, low WIDTH bits.
- Flags:
  - zer = (w == 0).
  - neg = w[WIDTH-1].
  - cout:
    - opc 0xx: carry out of bit WIDTH-1 of the full-width sum.
    - opc 10x, 110: 0.
    - opc 111: 1 iff the high WIDTH product bits are nonzero.
  - ovf:
    - opc 0xx: signed overflow, i.e. both adder inputs share a sign and the result sign differs.
    - Otherwise: 0.
- States:
  - IDLE: in_ready = 1. Accepting opc ≠ 111 writes w and flags at the accepting edge and stays in IDLE. Accepting opc 111 loads the multiplicand and multiplier, clears the accumulator, sets the counter to WIDTH and goes to MUL.
  - MUL: in_ready = 0; in_valid is ignored. Each edge adds the multiplicand if the multiplier LSB is 1, shifts, and decrements the counter. At the edge where the counter reaches 0, write w and flags, pulse out_valid, and return to IDLE.
- w and flags hold their values between results. No backpressure: out_valid is never stalled.
- Reset values: w = 0, zer = 0, neg = 0, cout = 0, ovf = 0, out_valid = 0, state = IDLE, so in_ready = 1.
- rst_n low mid-MUL aborts the multiply. No out_valid is produced for it, and the block returns to IDLE with all outputs at their reset values.

## Timing

- Non-multiply request accepted in cycle N: out_valid = 1 and the new w/flags are visible in cycle N+1.
- Back-to-back non-multiply requests are accepted every cycle with full throughput.
- Multiply accepted in cycle N: in_ready = 0 in cycles N+1 through N+WIDTH. out_valid = 1 in cycle N+WIDTH+1, and in_ready = 1 in that same cycle.
- A request presented in the out_valid cycle is accepted, so there is no bubble.
- All outputs are registered. in_ready is decoded from the state register only.

## Structure

- Package alu_pkg:
  - Opcode localparams: OP_NEG, OP_INC, OP_ADC, OP_ADDSH, OP_AND, OP_OR, OP_MIX, OP_MUL.
  - State encoding: ST_IDLE, ST_MUL.
- Sub-module alu_mul_seq holds the shift-add multiplier: operand registers, the WIDTH+1-bit accumulator, and a $clog2(WIDTH+1) counter. It has a start/done interface.
- The top level keeps the combinational adder/logic path, the flag logic and the FSM.

## Test plan

All scenarios use WIDTH = 16.
- Reset: assert rst_n = 0 mid-simulation → all outputs 0, in_ready = 1, and this holds after release.
- opc 010, ina = 0x7FFF, inb = 0x0001, inc = 0 → next cycle w = 0x8000, neg = 1, ovf = 1, cout = 0, zer = 0.
- opc 000, ina = 0x0000 → w = 0x0000, zer = 1, cout = 1. Then opc 011, ina = 0x0010, inb = 0xFFF0 → w = 0x0008, cout = 1, ovf = 0.
- Back-to-back in consecutive cycles:
  - opc 100, ina = 0x12F0, inb = 0x0F3C → w = 0x0230.
  - opc 110 with the same operands → w = 0xF03C, neg = 1.
  - Expect two consecutive out_valid pulses.
- opc 111, ina = 0x0100, inb = 0x0100:
  - in_ready = 0 for 16 cycles; a request held during that window is not accepted.
  - out_valid arrives 17 cycles after acceptance with w = 0x0000, zer = 1, cout = 1.
  - Then opc 111 with 0x00FF × 0x0101 → w = 0xFFFF, cout = 0, neg = 1.
- Start opc 111, then assert rst_n = 0 during the 5th MUL cycle → no out_valid, outputs 0, in_ready = 1. A following opc 001, ina = 0xFFFF → w = 0x0000, zer = 1, cout = 1.
